imem_sync: RTL and testbench

Parametrised, synchronous-read instruction memory for the next-generation RISC-V core. It replaces the combinational fetch path with a valid/ready request/response interface and a configurable number of wait states, so the fetch stage can be verified against realistic memory latency. It also reports misaligned and out-of-range fetches, and provides an optional program-load write port. It sits between the fetch stage (PC side) and the decode stage (instruction side).

---
 rtl/imem_sync.sv | 125 ++++++++++++
 tb/tb_imem_sync.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_sync.sv
// Purpose: synchronous-read instruction memory with a valid/ready fetch interface and optional program-load port.
// Latency: a request accepted at edge N presents rsp_valid from edge N+1+WAIT_CYCLES; one request outstanding.
// Backpressure: response outputs hold while rsp_valid && !rsp_ready; req_ready stays low until the response is taken.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset (memory contents survive reset)
//   req_valid/req_ready/req_addr        fetch request, byte address
//   rsp_valid/rsp_ready/rsp_instr/rsp_fault  fetch response; fault = misaligned or out of range
//   load_en/load_addr/load_data         program-load write port (word address = load_addr[31:2])
// Build option: define IMEM_LOAD_PORT_EN to let the load port write the array; otherwise the
// load inputs are ignored and the array is read-only after elaboration.
module imem_sync #(
    parameter int    DEPTH       = 1024,
    parameter int    WAIT_CYCLES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic        rsp_fault,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [29:0] DEPTH_W   = 30'(DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    // ST_RST holds req_ready low while rst is asserted; the block becomes ready
    // one edge after rst is sampled low. ST_READ is the array capture cycle.
    localparam logic [2:0] ST_RST  = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_READ = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    logic [31:0]   mem [DEPTH];
    logic [2:0]    state;
    logic [3:0]    cnt;
    logic [31:0]   addr_q;
    logic          fetch_fault;
    logic [AW-1:0] idx;

    // Power-up image: every word a NOP.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = NOP;
        end
    end

    // Range check uses the full word index; truncation happens only afterwards.
    assign fetch_fault = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DEPTH_W);
    assign idx         = addr_q[AW+1:2];

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RST;
            cnt       <= '0;
            addr_q    <= '0;
            rsp_instr <= NOP;
            rsp_fault <= 1'b0;
        end else begin
            case (state)
                ST_RST: begin
                    state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        cnt    <= WAIT_INIT;
                        state  <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_READ;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_READ;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_READ: begin
                    // A load hitting the same word on this edge is not visible here:
                    // the non-blocking read returns the pre-write contents.
                    rsp_instr <= fetch_fault ? NOP : mem[idx];
                    rsp_fault <= fetch_fault;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef IMEM_LOAD_PORT_EN
    // Loads are independent of the fetch FSM and of rst; out-of-range words are dropped.
    always_ff @(posedge clk) begin
        if (load_en && (load_addr[31:2] < DEPTH_W)) begin
            mem[load_addr[AW+1:2]] <= load_data;
        end
    end

    logic unused_load_lsb;
    assign unused_load_lsb = ^load_addr[1:0];
`else
    logic unused_load;
    assign unused_load = ^{load_en, load_addr, load_data};
`endif

endmodule

// File: tb/tb_imem_sync.sv
module tb_imem_sync;

    localparam int          DEPTH = 1024;
    localparam int          NI    = 3;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic        clk;
    logic        rst       [NI];
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic [31:0] req_addr  [NI];
    logic        rsp_valid [NI];
    logic        rsp_ready [NI];
    logic [31:0] rsp_instr [NI];
    logic        rsp_fault [NI];
    logic        load_en   [NI];
    logic [31:0] load_addr [NI];
    logic [31:0] load_data [NI];

    int checks   = 0;
    int failures = 0;

    exp_t        sb [$];
    logic [31:0] model_mem [int];

    // Instance 0: WAIT_CYCLES=1, instance 1: WAIT_CYCLES=0, instance 2: WAIT_CYCLES=3.
    imem_sync #(.DEPTH(DEPTH), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_instr(rsp_instr[0]), .rsp_fault(rsp_fault[0]),
        .load_en(load_en[0]), .load_addr(load_addr[0]), .load_data(load_data[0])
    );

    imem_sync #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_instr(rsp_instr[1]), .rsp_fault(rsp_fault[1]),
        .load_en(load_en[1]), .load_addr(load_addr[1]), .load_data(load_data[1])
    );

    imem_sync #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst[2]),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_addr(req_addr[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_instr(rsp_instr[2]), .rsp_fault(rsp_fault[2]),
        .load_en(load_en[2]), .load_addr(load_addr[2]), .load_data(load_data[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wait_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour: only instance 0 ever receives loads.
    function automatic exp_t predict(input int k, input logic [31:0] a);
        exp_t e;
        e.instr = NOP;
        e.fault = 1'b0;
        if ((a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH))) begin
            e.fault = 1'b1;
        end else if ((k == 0) && model_mem.exists(int'(a[31:2]))) begin
            e.instr = model_mem[int'(a[31:2])];
        end
        return e;
    endfunction

    function automatic void model_update(input int k, input logic [31:0] a, input logic [31:0] d);
`ifdef IMEM_LOAD_PORT_EN
        if ((k == 0) && ({2'b00, a[31:2]} < 32'(DEPTH))) begin
            model_mem[int'(a[31:2])] = d;
        end
`else
        if ((k == 0) && (a == 32'hFFFF_FFFF) && (d == 32'h0)) begin
            model_mem[0] = model_mem[0];
        end
`endif
    endfunction

    task automatic do_load(input int k, input logic [31:0] a, input logic [31:0] d);
        load_en[k]   = 1'b1;
        load_addr[k] = a;
        load_data[k] = d;
        @(posedge clk); #1;
        load_en[k] = 1'b0;
        model_update(k, a, d);
    endtask

    // Called #1 after a rising edge with the target instance idle. Optionally
    // drives a load on the edge where the array is captured.
    task automatic fetch(input int k, input logic [31:0] a, input int stall,
                         input logic ld, input logic [31:0] ld_a, input logic [31:0] ld_d);
        exp_t e;
        int   lat;
        int   cap;
        cap = wait_of(k) + 1;
        chk("req_ready_idle", 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1;
        req_addr[k]  = a;
        rsp_ready[k] = 1'b0;
        sb.push_back(predict(k, a));
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        chk("req_ready_busy", 32'(req_ready[k]), 32'd0);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            if (ld && (c == cap)) begin
                load_en[k]   = 1'b1;
                load_addr[k] = ld_a;
                load_data[k] = ld_d;
            end
            @(posedge clk); #1;
            if (ld && (c == cap)) begin
                load_en[k] = 1'b0;
                model_update(k, ld_a, ld_d);
            end
            if (rsp_valid[k]) begin
                lat = c;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(cap));
        e = sb.pop_front();
        if (lat != 0) begin
            chk("rsp_instr", rsp_instr[k], e.instr);
            chk("rsp_fault", 32'(rsp_fault[k]), 32'(e.fault));
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                chk("stall_valid", 32'(rsp_valid[k]), 32'd1);
                chk("stall_instr", rsp_instr[k], e.instr);
                chk("stall_fault", 32'(rsp_fault[k]), 32'(e.fault));
            end
            rsp_ready[k] = 1'b1;
            @(posedge clk); #1;
            rsp_ready[k] = 1'b0;
            chk("post_hs_valid", 32'(rsp_valid[k]), 32'd0);
            chk("post_hs_ready", 32'(req_ready[k]), 32'd1);
        end
    endtask

    initial begin
        logic seen;
        for (int k = 0; k < NI; k++) begin
            rst[k]       = 1'b1;
            req_valid[k] = 1'b0;
            req_addr[k]  = '0;
            rsp_ready[k] = 1'b0;
            load_en[k]   = 1'b0;
            load_addr[k] = '0;
            load_data[k] = '0;
        end

        // Reset values while rst is held.
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("rst_req_ready", 32'(req_ready[k]), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            chk("rst_rsp_instr", rsp_instr[k], NOP);
            chk("rst_rsp_fault", 32'(rsp_fault[k]), 32'd0);
        end
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < NI; k++) begin
            chk("ready_after_rst", 32'(req_ready[k]), 32'd1);
        end

        // Default contents, then loaded program with a 3-cycle stall on the first fetch.
        fetch(0, 32'h0, 0, 1'b0, 32'h0, 32'h0);
        do_load(0, 32'h0, 32'h0050_0093);
        do_load(0, 32'h4, 32'h0060_0113);
        fetch(0, 32'h0, 3, 1'b0, 32'h0, 32'h0);
        fetch(0, 32'h4, 0, 1'b0, 32'h0, 32'h0);

        // Faults and range boundaries.
        fetch(0, 32'h2, 0, 1'b0, 32'h0, 32'h0);
        fetch(0, 32'h1000, 1, 1'b0, 32'h0, 32'h0);
        fetch(0, 32'hFFFF_FFF0, 0, 1'b0, 32'h0, 32'h0);
        fetch(0, 32'hFFC, 0, 1'b0, 32'h0, 32'h0);

        // Out-of-range load must not alias onto word 0.
        do_load(0, 32'h1000, 32'hBAD0_BAD0);
        fetch(0, 32'h0, 0, 1'b0, 32'h0, 32'h0);
        do_load(0, 32'hFFE, 32'h1234_5678);
        fetch(0, 32'hFFC, 0, 1'b0, 32'h0, 32'h0);

        // Latency for WAIT_CYCLES = 0 and 3.
        fetch(1, 32'h8, 0, 1'b0, 32'h0, 32'h0);
        fetch(2, 32'h8, 2, 1'b0, 32'h0, 32'h0);

        // Load on the capture edge returns the old word; a re-fetch sees the new one.
        fetch(0, 32'hC, 0, 1'b1, 32'hC, 32'hDEAD_BEEF);
        fetch(0, 32'hC, 0, 1'b0, 32'h0, 32'h0);

        // Reset one cycle into WAIT: the pending response must never appear.
        req_valid[2] = 1'b1;
        req_addr[2]  = 32'h8;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        chk("midrst_busy", 32'(req_ready[2]), 32'd0);
        rst[2] = 1'b1;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        chk("midrst_valid", 32'(rsp_valid[2]), 32'd0);
        chk("midrst_ready_low", 32'(req_ready[2]), 32'd0);
        @(posedge clk); #1;
        chk("midrst_ready", 32'(req_ready[2]), 32'd1);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rsp_valid[2]) seen = 1'b1;
        end
        chk("midrst_ghost_rsp", 32'(seen), 32'd0);
        fetch(2, 32'h4, 0, 1'b0, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
